fir_axil_master: RTL and testbench

//  AXI4-Lite initiator that programs and polls the fir block over its AW/W/AR/R slave port.
//  It turns a simple one-at-a-time command/response interface into AXI-Lite single-beat transactions.
//  A testbench or SoC sequencer uses it to load taps (0x20-0xFF), set data_length (0x10), set ap_start (0x00) and poll status.
//  The slave has no B channel: a write completes when both the AW and W handshakes have occurred.

---
 rtl/fir_axil_pkg.sv | 29 ++
 rtl/axil_timeout_cnt.sv | 43 ++++
 rtl/fir_axil_master.sv | 198 +++++++++++++++++++
 tb/tb_fir_axil_master.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fir_axil_pkg.sv
// ---------------------------------------------------------------------------
// fir_axil_pkg
//   Shared definitions for the fir AXI4-Lite initiator:
//   - FSM state encoding used by fir_axil_master
//   - fir register map (ap_ctrl, data_length, tap window)
//   - ap_ctrl status bit positions
// ---------------------------------------------------------------------------
package fir_axil_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_AR   = 3'd2,
    ST_R    = 3'd3,
    ST_RSP  = 3'd4
  } state_t;

  // fir register map
  localparam logic [11:0] ADDR_AP_CTRL  = 12'h000;
  localparam logic [11:0] ADDR_DATA_LEN = 12'h010;
  localparam logic [11:0] ADDR_TAP_BASE = 12'h020;
  localparam logic [11:0] ADDR_TAP_LAST = 12'h0FF;

  // ap_ctrl bit positions
  localparam int STAT_AP_START = 0;
  localparam int STAT_AP_DONE  = 1;
  localparam int STAT_AP_IDLE  = 2;

endpackage

// File: rtl/axil_timeout_cnt.sv
// ---------------------------------------------------------------------------
// axil_timeout_cnt
//   Watchdog counter for the AXI-Lite initiator. Counts cycles while i_inc
//   is high, restarts from zero on i_clr. o_expired is asserted in the cycle
//   in which the count reaches LIMIT, so a transaction stalled for LIMIT
//   cycles is abandoned at the end of its LIMIT-th cycle.
// Ports
//   axis_clk    in  clock
//   axis_rst_n  in  asynchronous active-low reset
//   i_clr       in  restart count (state change)
//   i_inc       in  count this cycle (waiting on the slave)
//   o_expired   out limit reached this cycle
// ---------------------------------------------------------------------------
module axil_timeout_cnt #(
  parameter int LIMIT = 255
) (
  input  logic axis_clk,
  input  logic axis_rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expired
);

  localparam int CNT_W = (LIMIT < 2) ? 1 : $clog2(LIMIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // r_cnt holds the number of cycles already waited; the current cycle
  // is the LIMIT-th one when r_cnt == LIMIT-1.
  assign o_expired = i_inc && (r_cnt == LAST);

endmodule

// File: rtl/fir_axil_master.sv
// ---------------------------------------------------------------------------
// fir_axil_master
//   AXI4-Lite initiator that converts a one-at-a-time command/response
//   interface into single-beat AXI-Lite transactions towards the fir block.
//   The slave has no B channel: a write is complete once both the AW and W
//   handshakes have happened (in either order or together).
//
//   Optional feature: define FIR_AXIL_MASTER_TIMEOUT_EN to build a watchdog
//   that abandons a stalled transaction after TIMEOUT_CYCLES and returns a
//   response with rsp_err=1. Without it the FSM waits forever and rsp_err=0.
//
// Ports
//   axis_clk, axis_rst_n         clock, asynchronous active-low reset
//   cmd_valid/cmd_ready          command handshake (cmd_ready=1 only in IDLE)
//   cmd_write, cmd_addr, cmd_wdata  command payload
//   rsp_valid/rsp_ready          response handshake
//   rsp_rdata, rsp_err           read data (0 for writes), timeout flag
//   awvalid/awready/awaddr       AXI-Lite write address
//   wvalid/wready/wdata          AXI-Lite write data
//   arvalid/arready/araddr       AXI-Lite read address
//   rvalid/rready/rdata          AXI-Lite read data
// ---------------------------------------------------------------------------
module fir_axil_master
  import fir_axil_pkg::*;
#(
  parameter int pADDR_WIDTH    = 12,
  parameter int pDATA_WIDTH    = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  // command / response
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [pADDR_WIDTH-1:0] cmd_addr,
  input  logic [pDATA_WIDTH-1:0] cmd_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [pDATA_WIDTH-1:0] rsp_rdata,
  output logic                   rsp_err,
  // AXI-Lite
  output logic                   awvalid,
  input  logic                   awready,
  output logic [pADDR_WIDTH-1:0] awaddr,
  output logic                   wvalid,
  input  logic                   wready,
  output logic [pDATA_WIDTH-1:0] wdata,
  output logic                   arvalid,
  input  logic                   arready,
  output logic [pADDR_WIDTH-1:0] araddr,
  input  logic                   rvalid,
  output logic                   rready,
  input  logic [pDATA_WIDTH-1:0] rdata
);

  state_t                 r_state;
  state_t                 w_state_norm;   // next state ignoring the watchdog
  state_t                 w_state_next;
  logic [pADDR_WIDTH-1:0] r_addr;
  logic [pDATA_WIDTH-1:0] r_wdata;
  logic [pDATA_WIDTH-1:0] r_rsp_rdata;
  logic                   r_aw_done;
  logic                   r_w_done;
  logic                   w_accept;
  logic                   w_expired;
  logic                   w_timed_out;

  assign w_accept = (r_state == ST_IDLE) && cmd_valid;

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next state and handshake outputs. The AXI valids are decoded from
  // the state register plus the per-channel done flags, so they are glitch
  // free and fall to 0 the instant reset is asserted.
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_norm = r_state;
    cmd_ready    = 1'b0;
    awvalid      = 1'b0;
    wvalid       = 1'b0;
    arvalid      = 1'b0;
    rready       = 1'b0;
    rsp_valid    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) w_state_norm = cmd_write ? ST_WR : ST_AR;
      end
      ST_WR: begin
        awvalid = !r_aw_done;
        wvalid  = !r_w_done;
        // Each channel is finished if it was already done or handshakes now.
        if ((r_aw_done || awready) && (r_w_done || wready)) w_state_norm = ST_RSP;
      end
      ST_AR: begin
        arvalid = 1'b1;
        if (arready) w_state_norm = ST_R;
      end
      ST_R: begin
        rready = 1'b1;
        if (rvalid) w_state_norm = ST_RSP;
      end
      ST_RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_state_norm = ST_IDLE;
      end
      default: w_state_norm = ST_IDLE;
    endcase
    // A handshake completing in the expiry cycle wins over the watchdog.
    w_timed_out  = w_expired && (w_state_norm == r_state);
    w_state_next = w_timed_out ? ST_RSP : w_state_norm;
  end

  // -------------------------------------------------------------------------
  // Datapath: latched command, write progress flags, response data
  // -------------------------------------------------------------------------
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_addr    <= cmd_addr;
        r_wdata   <= cmd_wdata;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
      if (r_state == ST_WR) begin
        if (awready) r_aw_done <= 1'b1;
        if (wready)  r_w_done  <= 1'b1;
      end
      // Loaded once on entry to RSP; only a genuine R beat carries data.
      if ((r_state != ST_RSP) && (w_state_next == ST_RSP)) begin
        r_rsp_rdata <= ((r_state == ST_R) && !w_timed_out) ? rdata : '0;
      end
    end
  end

  assign awaddr    = r_addr;
  assign araddr    = r_addr;
  assign wdata     = r_wdata;
  assign rsp_rdata = r_rsp_rdata;

  // -------------------------------------------------------------------------
  // Optional watchdog
  // -------------------------------------------------------------------------
`ifdef FIR_AXIL_MASTER_TIMEOUT_EN
  logic w_cnt_clr;
  logic w_cnt_inc;
  logic r_rsp_err;

  assign w_cnt_clr = (w_state_next != r_state);
  assign w_cnt_inc = (r_state == ST_WR) || (r_state == ST_AR) || (r_state == ST_R);

  axil_timeout_cnt #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .axis_clk  (axis_clk),
    .axis_rst_n(axis_rst_n),
    .i_clr     (w_cnt_clr),
    .i_inc     (w_cnt_inc),
    .o_expired (w_expired)
  );

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_rsp_err <= 1'b0;
    end else if (w_timed_out) begin
      r_rsp_err <= 1'b1;
    end else if ((r_state == ST_RSP) && rsp_ready) begin
      r_rsp_err <= 1'b0;
    end
  end

  assign rsp_err = r_rsp_err;
`else
  logic w_unused_timeout;

  assign w_expired        = 1'b0;
  assign rsp_err          = 1'b0;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

endmodule

// File: tb/tb_fir_axil_master.sv
// ---------------------------------------------------------------------------
// tb_fir_axil_master
//   Directed-plus-random bench for fir_axil_master. A cycle-by-cycle slave
//   model lives in the do_cmd task; a separate reference register array holds
//   what the fir registers should contain after each completed write.
//   Define FIR_AXIL_MASTER_TIMEOUT_EN to also exercise the watchdog
//   (TIMEOUT_CYCLES is set to 8 here).
// ---------------------------------------------------------------------------
module tb_fir_axil_master;
  import fir_axil_pkg::*;

  localparam int TO_CYC = 8;

  logic        axis_clk;
  logic        axis_rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        awvalid, awready, wvalid, wready, arvalid, arready, rvalid, rready;
  logic [11:0] awaddr, araddr;
  logic [31:0] wdata, rdata;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] ref_mem   [logic [11:0]];  // expected register contents
  logic [31:0] slave_mem [logic [11:0]];  // what the slave actually received

  fir_axil_master #(
    .pADDR_WIDTH   (12),
    .pDATA_WIDTH   (32),
    .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .axis_clk  (axis_clk),
    .axis_rst_n(axis_rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .awvalid   (awvalid),
    .awready   (awready),
    .awaddr    (awaddr),
    .wvalid    (wvalid),
    .wready    (wready),
    .wdata     (wdata),
    .arvalid   (arvalid),
    .arready   (arready),
    .araddr    (araddr),
    .rvalid    (rvalid),
    .rready    (rready),
    .rdata     (rdata)
  );

  initial axis_clk = 1'b0;
  always #5 axis_clk = ~axis_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic slave_idle();
    awready = 1'b0; wready = 1'b0; arready = 1'b0; rvalid = 1'b0; rdata = '0;
  endtask

  // One command from issue to response consumption. Called just after a
  // negedge with the DUT in IDLE. Delays are in cycles after cycle 1.
  task automatic do_cmd(input logic wr, input logic [11:0] addr, input logic [31:0] data,
                        input int aw_dly, input int w_dly, input int ar_dly, input int r_dly,
                        input int rsp_dly, input logic junk_r);
    int          k, exp_lat, done_cyc, rv_cyc;
    logic        aw_d, w_d, ar_d, committed, exp_err;
    logic [11:0] s_awaddr, s_araddr;
    logic [31:0] s_wdata, exp_rd;
    // expectations from the protocol rules
    exp_err = 1'b0;
    rv_cyc  = 2 + ar_dly + r_dly;
    if (wr) begin
      done_cyc = (aw_dly > w_dly) ? 1 + aw_dly : 1 + w_dly;
      exp_lat  = done_cyc + 1;
      exp_rd   = '0;
`ifdef FIR_AXIL_MASTER_TIMEOUT_EN
      if (done_cyc > TO_CYC) begin
        exp_lat = TO_CYC + 1;
        exp_err = 1'b1;
      end
`endif
    end else begin
      exp_lat = rv_cyc + 1;
      exp_rd  = ref_mem.exists(addr) ? ref_mem[addr] : '0;
    end
    // cycle 0: accept
    check("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; rsp_ready = 1'b0;
    slave_idle();
    @(negedge axis_clk);
    cmd_valid = 1'b0; cmd_addr = 12'($urandom); cmd_wdata = $urandom;
    k = 1; aw_d = 0; w_d = 0; ar_d = 0; committed = 0;
    s_awaddr = '0; s_araddr = '0; s_wdata = '0;
    while (rsp_valid !== 1'b1 && k < 64) begin
      check("cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
      if (wr) begin
        check("awvalid", {31'd0, awvalid}, {31'd0, !aw_d});
        check("wvalid", {31'd0, wvalid}, {31'd0, !w_d});
        check("arvalid_wr", {31'd0, arvalid}, 32'd0);
        if (!aw_d) check("awaddr", {20'd0, awaddr}, {20'd0, addr});
        if (!w_d) check("wdata", wdata, data);
        awready = (k >= 1 + aw_dly);
        wready  = (k >= 1 + w_dly);
        if (awvalid && awready && !aw_d) begin aw_d = 1; s_awaddr = awaddr; end
        if (wvalid && wready && !w_d) begin w_d = 1; s_wdata = wdata; end
        if (aw_d && w_d && !committed) begin
          committed = 1;
          slave_mem[s_awaddr] = s_wdata;
        end
      end else begin
        check("arvalid", {31'd0, arvalid}, {31'd0, !ar_d});
        check("rready", {31'd0, rready}, {31'd0, ar_d});
        check("awvalid_rd", {31'd0, awvalid}, 32'd0);
        if (!ar_d) begin
          check("araddr", {20'd0, araddr}, {20'd0, addr});
          arready = (k >= 1 + ar_dly);
          rvalid  = junk_r;
          rdata   = 32'hBAD0_0000 | k;
          if (arvalid && arready) begin ar_d = 1; s_araddr = araddr; end
        end else begin
          arready = 1'b0;
          rvalid  = (k >= rv_cyc);
          rdata   = rvalid ? (slave_mem.exists(s_araddr) ? slave_mem[s_araddr] : '0) : 32'hDEAD_BEEF;
        end
      end
      @(negedge axis_clk);
      k++;
    end
    slave_idle();
    check("latency", k, exp_lat);
    check("rsp_valids_low", {28'd0, awvalid, wvalid, arvalid, rready}, 32'd0);
    check("rsp_rdata", rsp_rdata, exp_rd);
    check("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
    // hold the response; a pending command must not be taken
    for (int h = 0; h < rsp_dly; h++) begin
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = ADDR_TAP_LAST - 12'd3; cmd_wdata = 32'hFFFF_0000;
      @(negedge axis_clk);
      check("rsp_hold_valid", {31'd0, rsp_valid}, 32'd1);
      check("rsp_hold_rdata", rsp_rdata, exp_rd);
      check("rsp_hold_nocmd", {31'd0, cmd_ready}, 32'd0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge axis_clk);
    rsp_ready = 1'b0;
    check("rsp_consumed", {30'd0, rsp_valid, rsp_err}, 32'd0);
    if (wr && !exp_err) ref_mem[addr] = data;
    $display("[TB] %s addr=%h data=%h lat=%0d rdata=%h err=%b",
             wr ? "WR" : "RD", addr, data, k, rsp_rdata, exp_err);
  endtask

  initial begin
    logic [11:0] a;
    logic [31:0] d;
    axis_rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0;
    slave_idle();
    #12;
    check("reset_ready", {31'd0, cmd_ready}, 32'd1);
    check("reset_valids", {27'd0, rsp_valid, awvalid, wvalid, arvalid, rready}, 32'd0);
    check("reset_data", {20'd0, awaddr} | {20'd0, araddr} | wdata | rsp_rdata | {31'd0, rsp_err}, 32'd0);
    @(negedge axis_clk); axis_rst_n = 1'b1;
    @(negedge axis_clk);

    ref_mem[ADDR_AP_CTRL]   = 32'd1 << STAT_AP_IDLE;
    slave_mem[ADDR_AP_CTRL] = 32'd1 << STAT_AP_IDLE;

    // 1: AW at cycle 1, W at cycle 3
    do_cmd(1'b1, ADDR_TAP_BASE, 32'h0000_000A, 0, 2, 0, 0, 0, 1'b0);
    // 2: status read, rvalid 2 cycles late, early rvalid while in AR
    do_cmd(1'b0, ADDR_AP_CTRL, 32'h0, 0, 0, 1, 2, 0, 1'b1);
    // 3: eleven taps, back-to-back except one held response, then readback
    for (int i = 0; i < 11; i++) begin
      a = ADDR_TAP_BASE + 12'(4 * i);
      d = $urandom;
      do_cmd(1'b1, a, d, $urandom_range(0, 3), $urandom_range(0, 3), 0, 0, (i == 5) ? 5 : 0, 1'b0);
    end
    for (int i = 0; i < 11; i++) begin
      a = ADDR_TAP_BASE + 12'(4 * i);
      do_cmd(1'b0, a, 32'h0, 0, 0, $urandom_range(0, 3), $urandom_range(0, 3),
             (i == 5) ? 5 : $urandom_range(0, 1), 1'($urandom_range(0, 1)));
    end
    do_cmd(1'b1, ADDR_DATA_LEN, $urandom, 1, 0, 0, 0, 0, 1'b0);
    do_cmd(1'b0, ADDR_DATA_LEN, 32'h0, 0, 0, 0, 0, 0, 1'b0);
`ifdef FIR_AXIL_MASTER_TIMEOUT_EN
    // 4: awready never comes
    do_cmd(1'b1, ADDR_TAP_BASE + 12'h004, 32'h5555_5555, 100, 0, 0, 0, 0, 1'b0);
    do_cmd(1'b0, ADDR_TAP_BASE + 12'h004, 32'h0, 0, 0, 0, 1, 0, 1'b0);
`endif
    // 5: asynchronous reset in the middle of a write
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = ADDR_DATA_LEN; cmd_wdata = 32'hDEAD;
    @(negedge axis_clk);
    cmd_valid = 1'b0;
    check("pre_reset_awvalid", {31'd0, awvalid}, 32'd1);
    #2 axis_rst_n = 1'b0;
    #1;
    check("async_reset_valids", {27'd0, rsp_valid, awvalid, wvalid, arvalid, rready}, 32'd0);
    check("async_reset_ready", {31'd0, cmd_ready}, 32'd1);
    check("async_reset_data", wdata | {20'd0, awaddr} | rsp_rdata, 32'd0);
    @(negedge axis_clk); axis_rst_n = 1'b1;
    @(negedge axis_clk);
    do_cmd(1'b1, ADDR_DATA_LEN, 32'h0000_0258, 0, 0, 0, 0, 0, 1'b0);
    do_cmd(1'b0, ADDR_DATA_LEN, 32'h0, 0, 0, 0, 0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
